// File: rtl/rename_table_pkg.sv
// Shared constants and helpers for the register alias table write side.
package rename_table_pkg;

    localparam int DEF_PR_ADDR_W      = 5;
    localparam int DEF_NUM_PHYS       = 32;
    localparam int DEF_FL_DEPTH       = 32;
    localparam int ARCH_W             = 4;
    localparam int NUM_ARCH_RENAMED   = 10;
    localparam int FIRST_RENAMED_ARCH = 2;
    localparam int FIRST_FREE_PHYS    = FIRST_RENAMED_ARCH + NUM_ARCH_RENAMED;

    // Arch 0/1 are hardwired constants; 12..15 do not exist and get the same treatment.
    function automatic logic is_renamed(input logic [ARCH_W-1:0] arch);
        return (arch >= ARCH_W'(FIRST_RENAMED_ARCH)) && (arch < ARCH_W'(FIRST_FREE_PHYS));
    endfunction

endpackage

// File: rtl/rename_table_if.sv
// Allocation / writeback / free handshake and RAT view between rename and the alias table.
interface rename_table_if #(
    parameter int PR_ADDR_W = rename_table_pkg::DEF_PR_ADDR_W
);
    import rename_table_pkg::*;

    logic                                  alloc_valid;
    logic [ARCH_W-1:0]                     alloc_arch;
    logic                                  alloc_ready;
    logic [PR_ADDR_W-1:0]                  alloc_phys;
    logic [PR_ADDR_W-1:0]                  alloc_old_phys;
    logic                                  wb_valid;
    logic [PR_ADDR_W-1:0]                  wb_phys;
    logic                                  free_valid;
    logic [PR_ADDR_W-1:0]                  free_phys;
    logic [NUM_ARCH_RENAMED-1:0]           rat_done;
    logic [PR_ADDR_W*NUM_ARCH_RENAMED-1:0] rat_aliases;
    logic [PR_ADDR_W:0]                    fl_count;

    modport master (
        output alloc_valid, alloc_arch, wb_valid, wb_phys, free_valid, free_phys,
        input  alloc_ready, alloc_phys, alloc_old_phys, rat_done, rat_aliases, fl_count
    );

    modport slave (
        input  alloc_valid, alloc_arch, wb_valid, wb_phys, free_valid, free_phys,
        output alloc_ready, alloc_phys, alloc_old_phys, rat_done, rat_aliases, fl_count
    );

endinterface

// File: rtl/rename_free_list.sv
// FIFO of unallocated physical registers, preloaded at reset with the non-architectural ones.
module rename_free_list
    import rename_table_pkg::*;
#(
    parameter int PR_ADDR_W = DEF_PR_ADDR_W,
    parameter int FL_DEPTH  = DEF_FL_DEPTH,
    parameter int NUM_PHYS  = DEF_NUM_PHYS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [PR_ADDR_W-1:0] push_phys,
    input  logic                 pop,
    output logic [PR_ADDR_W-1:0] head,
    output logic [PR_ADDR_W:0]   count
);

    localparam int PTR_W   = $clog2(FL_DEPTH);
    localparam int PRELOAD = NUM_PHYS - FIRST_FREE_PHYS;

    logic [PR_ADDR_W-1:0] mem_q [FL_DEPTH];
    logic [PTR_W-1:0]     head_ptr;
    logic [PTR_W-1:0]     tail_ptr;
    logic [PR_ADDR_W:0]   count_q;
    logic                 push_ok;
    logic                 pop_ok;

    // A full list silently drops the push; an empty list ignores the pop.
    assign push_ok = push && (count_q != (PR_ADDR_W+1)'(FL_DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= (i < unsigned'(PRELOAD)) ? PR_ADDR_W'(i + FIRST_FREE_PHYS) : '0;
            end
            head_ptr <= '0;
            tail_ptr <= PTR_W'(PRELOAD);
            count_q  <= (PR_ADDR_W+1)'(PRELOAD);
        end else begin
            if (push_ok) begin
                mem_q[tail_ptr] <= push_phys;
                tail_ptr        <= tail_ptr + 1'b1;
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[head_ptr];
    assign count = count_q;

endmodule

// File: rtl/rename_table.sv
// Register alias table write side: allocates phys destinations, tracks done bits, recycles freed regs.
module rename_table
    import rename_table_pkg::*;
#(
    parameter int PR_ADDR_W = DEF_PR_ADDR_W,
    parameter int NUM_PHYS  = DEF_NUM_PHYS,
    parameter int FL_DEPTH  = DEF_FL_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    rename_table_if.slave  rt
);

    logic [PR_ADDR_W-1:0]        alias_q [NUM_ARCH_RENAMED];
    logic [NUM_ARCH_RENAMED-1:0] done_q;
    logic [PR_ADDR_W-1:0]        fl_head;
    logic [PR_ADDR_W:0]          fl_cnt;
    logic                        renamed;
    logic                        fl_empty;
    logic                        fire;
    logic                        push;

    assign renamed  = is_renamed(rt.alloc_arch);
    assign fl_empty = (fl_cnt == '0);
    assign fire     = rt.alloc_valid && renamed && !fl_empty;
    assign push     = rt.free_valid && (rt.free_phys > PR_ADDR_W'(1));

    rename_free_list #(
        .PR_ADDR_W (PR_ADDR_W),
        .FL_DEPTH  (FL_DEPTH),
        .NUM_PHYS  (NUM_PHYS)
    ) u_free_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_phys (rt.free_phys),
        .pop       (fire),
        .head      (fl_head),
        .count     (fl_cnt)
    );

    always_comb begin
        rt.alloc_ready    = 1'b1;
        rt.alloc_phys     = '0;
        rt.alloc_old_phys = '0;
        if (renamed) begin
            rt.alloc_ready = !fl_empty;
            rt.alloc_phys  = fl_head;
            for (int unsigned i = 0; i < NUM_ARCH_RENAMED; i++) begin
                if (rt.alloc_arch == ARCH_W'(i + FIRST_RENAMED_ARCH)) begin
                    rt.alloc_old_phys = alias_q[i];
                end
            end
        end
    end

    // Allocation is written after the writeback CAM so it wins on the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ARCH_RENAMED; i++) begin
                alias_q[i] <= PR_ADDR_W'(i + FIRST_RENAMED_ARCH);
            end
            done_q <= '1;
        end else begin
            for (int unsigned i = 0; i < NUM_ARCH_RENAMED; i++) begin
                if (rt.wb_valid && (alias_q[i] == rt.wb_phys)) begin
                    done_q[i] <= 1'b1;
                end
                if (fire && (rt.alloc_arch == ARCH_W'(i + FIRST_RENAMED_ARCH))) begin
                    alias_q[i] <= fl_head;
                    done_q[i]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rt.rat_aliases = '0;
        for (int unsigned i = 0; i < NUM_ARCH_RENAMED; i++) begin
            rt.rat_aliases[i*PR_ADDR_W +: PR_ADDR_W] = alias_q[i];
        end
    end

    assign rt.rat_done = done_q;
    assign rt.fl_count = fl_cnt;

    a_legal_arch: assert property (@(posedge clk) disable iff (!rst_n)
        rt.alloc_valid |-> (rt.alloc_arch < ARCH_W'(FIRST_FREE_PHYS)));
    a_legal_free: assert property (@(posedge clk) disable iff (!rst_n)
        rt.free_valid |-> (rt.free_phys > PR_ADDR_W'(1)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        rt.free_valid |-> (fl_cnt != (PR_ADDR_W+1)'(FL_DEPTH)));

endmodule

// File: doc/rename_table.md
Name: rename_table

Overview:
- Write side of the register alias table (RAT) that the rename decoder reads.
- Allocates a physical destination register from a free list for each renamed microop and records the new alias with its done bit cleared.
- Sets done bits on writeback and accepts freed physical registers back from retirement.
- Drives rat_aliases/rat_done straight from its state registers, so the rename decoder sees updates the cycle after they occur.

Parameters:
- PR_ADDR_W, default `PR_ADDR_W (5): physical register index width.
- NUM_PHYS, default 32: physical register count. Phys 0/1 are the fixed constants for arch 0/1 and are never allocated.
- FL_DEPTH, default 32: free-list storage depth (power of two, at least NUM_PHYS-12).

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  rename stage presents a destination this cycle
- alloc_arch  in  4  destination arch reg (0..11)
- alloc_ready  out  1  allocation can be accepted
- alloc_phys  out  PR_ADDR_W  new phys reg for alloc_arch (combinational)
- alloc_old_phys  out  PR_ADDR_W  previous alias of alloc_arch, carried to ROB for later free (combinational)
- wb_valid  in  1  execution writeback
- wb_phys  in  PR_ADDR_W  phys reg written back
- free_valid  in  1  retirement returns a phys reg
- free_phys  in  PR_ADDR_W  phys reg returned
- rat_done  out  10  done bit per arch reg 2..11 (bit i = arch i+2)
- rat_aliases  out  PR_ADDR_W*10  alias per arch reg 2..11, field i at [i*PR_ADDR_W +: PR_ADDR_W]
- fl_count  out  PR_ADDR_W+1  free-list occupancy (debug/verif)

Behaviour:
- Reset (async, rst_n low):
  - alias[i] = i+2 and rat_done = 10'h3FF.
  - Free list holds phys 12..NUM_PHYS-1 in ascending order: head 12, fl_count = 20, alloc_ready = 1.
- Fire condition: fire = alloc_valid & alloc_ready.
- Arch 0/1 destination:
  - alloc_ready = 1, alloc_phys = 0, alloc_old_phys = 0.
  - No pop, no RAT change.
- Arch 2..11 destination:
  - alloc_ready = (fl_count != 0).
  - alloc_phys = free-list head; alloc_old_phys = alias[arch-2].
  - On fire: alias[arch-2] <= head, done[arch-2] <= 0, pop head. Takes effect at the next clock edge.
- Arch 12..15 destination: illegal. Treated as arch 0/1: no state change, and a simulation assertion fires.
- Writeback: every entry with alias == wb_phys has its done bit set to 1 next cycle. A wb_phys that matches no entry has no effect.
- Free: on free_valid, push free_phys at the tail.
  - Pushing phys 0/1 is illegal and is dropped.
  - Pushing when fl_count == FL_DEPTH is dropped.
  - Both cases raise an assertion.
- Same-cycle interactions:
  - Allocation and writeback hit the same entry: allocation wins (new alias, done = 0).
  - Push and pop in the same cycle: fl_count unchanged.
  - Pop from empty is impossible because alloc_ready gates it. A same-cycle free does NOT bypass into alloc_ready (no combinational free->alloc path).
- Ordering: free list is strict FIFO; head and tail pointers wrap modulo FL_DEPTH.
- Latency: RAT outputs are registered, 1 cycle from fire/wb edge to visibility. Allocation throughput is one per cycle.
- Reset mid-operation restores the full reset state regardless of pending handshakes.

Decomposition:
- Shared constants header (constants.vh): PR_ADDR_W, NUM_ARCH_RENAMED (10), FIRST_RENAMED_ARCH (2), NUM_PHYS.
- One sub-module, rename_free_list: synchronous FIFO with async active-low reset preloaded with 12..NUM_PHYS-1. Interface: push/pop/head/count. Parameters: PR_ADDR_W, FL_DEPTH.
- RAT state and writeback CAM stay in rename_table.

Test Plan:
- Reset check: after reset, rat_aliases field i = i+2, rat_done = 10'h3FF, fl_count = 20, alloc_phys head = 12.
- Single allocation: alloc arch 3 -> alloc_phys = 12, alloc_old_phys = 3. Next cycle alias[1] = 12, done[1] = 0, fl_count = 19. Then wb_phys = 12 -> done[1] = 1 next cycle.
- Exhaustion: 20 back-to-back allocs to arch 2 -> phys 12..31 issued in order, alloc_ready = 0 with fl_count = 0. A 21st alloc_valid held does not change state. free_phys = 3 -> next cycle alloc_ready = 1, alloc_phys = 3.
- Zero-destination handling: alloc arch 0 and arch 1 with fl_count = 0 -> alloc_ready = 1, no state change, alloc_phys = 0.
- Same-cycle collision: with alias[4] = 15 not done, alloc arch 6 and wb_phys = 15 in the same cycle -> alias[4] = new head, done[4] = 0.
- Concurrent free and alloc: at fl_count = 5, free_valid and alloc fire together -> fl_count stays 5, freed reg emerges after the 4 older entries. Assert rst_n low mid-burst -> full reset state immediately.
